// File: rtl/mips_pkg.sv
// Shared types for the forwarding/hazard logic: operand-select encoding,
// register-address width and the destination tag carried down the pipe.
package mips_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10,
      FWD_IMM   = 2'b11
   } fwd_sel_e;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dst;
      logic              reg_write;
   } dst_tag_t;

   // r0 is hardwired to zero, so a write to it is never a forwarding source.
   function automatic logic tag_hit(input dst_tag_t t, input logic [REG_AW-1:0] r);
      return t.valid && t.reg_write && (t.dst == r) && (r != '0);
   endfunction

endpackage

// File: rtl/dst_tag_stage.sv
// One pipeline slot of destination-register tracking; bubble loads an empty tag.
module dst_tag_stage
   import mips_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     bubble,
   input  dst_tag_t d,
   input  logic     d_mem_read,
   output dst_tag_t q,
   output logic     q_mem_read
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q          <= '0;
         q_mem_read <= 1'b0;
      end else if (bubble) begin
         q          <= '0;
         q_mem_read <= 1'b0;
      end else begin
         q          <= d;
         q_mem_read <= d_mem_read;
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select generation and load-use stall detection for the
// instruction moving from ID into EX.
module fwd_hazard_unit
   import mips_pkg::*;
#(
   parameter int REG_AW = mips_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_use_imm,
   input  logic              flush,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall
);

   dst_tag_t  id_tag, ex_tag, mem_tag, wb_tag;
   logic      ex_mem_read, mem_mem_read, wb_mem_read;
   logic      stall_c, ex_bubble;
   fwd_sel_e  a_nx, b_nx;
   logic      unused_tags;

   assign id_tag = '{valid: id_valid, dst: id_dst, reg_write: id_reg_write};

   dst_tag_stage u_ex (
      .clk(clk), .rst_n(rst_n), .bubble(ex_bubble),
      .d(id_tag), .d_mem_read(id_mem_read),
      .q(ex_tag), .q_mem_read(ex_mem_read)
   );

   dst_tag_stage u_mem (
      .clk(clk), .rst_n(rst_n), .bubble(1'b0),
      .d(ex_tag), .d_mem_read(1'b0),
      .q(mem_tag), .q_mem_read(mem_mem_read)
   );

   dst_tag_stage u_wb (
      .clk(clk), .rst_n(rst_n), .bubble(1'b0),
      .d(mem_tag), .d_mem_read(1'b0),
      .q(wb_tag), .q_mem_read(wb_mem_read)
   );

   // WB is tracked for pipeline visibility only; the register file handles
   // same-cycle write-then-read, so no select ever points at it.
   assign unused_tags = ^{wb_tag, mem_mem_read, wb_mem_read};

   always_comb begin
      stall_c = id_valid && !flush && ex_tag.valid && ex_mem_read &&
                (ex_tag.dst != '0) &&
                ((ex_tag.dst == id_rs) || (!id_use_imm && (ex_tag.dst == id_rt)));
      ex_bubble = flush || stall_c;
      a_nx = FWD_RF;
      b_nx = FWD_RF;
      if (!ex_bubble && id_valid) begin
         if (tag_hit(ex_tag, id_rs))       a_nx = FWD_EXMEM;
         else if (tag_hit(mem_tag, id_rs)) a_nx = FWD_MEMWB;
         if (id_use_imm)                   b_nx = FWD_IMM;
         else if (tag_hit(ex_tag, id_rt))  b_nx = FWD_EXMEM;
         else if (tag_hit(mem_tag, id_rt)) b_nx = FWD_MEMWB;
      end
   end

   assign stall = stall_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a_sel <= FWD_RF;
         fwd_b_sel <= FWD_RF;
      end else begin
         fwd_a_sel <= a_nx;
         fwd_b_sel <= b_nx;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scenarios plus a randomized run against an in-flight instruction list model.
module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_reg_write, id_mem_read, id_use_imm, flush;
   logic [4:0] id_rs, id_rt, id_dst;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic       stall;

   int checks = 0;
   int passed = 0;

   fwd_hazard_unit #(.REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_use_imm(id_use_imm), .flush(flush), .fwd_a_sel(fwd_a_sel),
      .fwd_b_sel(fwd_b_sel), .stall(stall)
   );

   always #5 clk = ~clk;

   // Model: the instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
   typedef struct {
      bit       valid;
      bit [4:0] dst;
      bit       writes;
      bit       load;
   } instr_t;
   instr_t pipe [3];

   function automatic void model_clear();
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
   endfunction

   function automatic bit model_writes_reg(int s, bit [4:0] r);
      return pipe[s].valid && pipe[s].writes && pipe[s].dst == r && r != 0;
   endfunction

   function automatic bit model_stall(bit v, bit [4:0] rs, bit [4:0] rt, bit imm, bit fl);
      bit reads_load;
      if (!v || fl || !pipe[0].valid || !pipe[0].load || pipe[0].dst == 0) return 0;
      reads_load = (pipe[0].dst == rs) || (!imm && pipe[0].dst == rt);
      return reads_load;
   endfunction

   // Producer one ahead delivers from EX/MEM, two ahead from MEM/WB.
   function automatic int model_src(bit [4:0] r);
      if (model_writes_reg(0, r)) return 1;
      if (model_writes_reg(1, r)) return 2;
      return 0;
   endfunction

   task automatic drive(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] dst,
                        input bit rw, input bit mr, input bit imm, input bit fl);
      @(negedge clk);
      id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
      id_reg_write = rw; id_mem_read = mr; id_use_imm = imm; flush = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall !== 1'b0)
         $display("FAIL reset_state: got a=%0d b=%0d stall=%0d expected 0/0/0", fwd_a_sel, fwd_b_sel, stall);
      else passed++;
      rst_n = 1'b1;
      idle(2);
      drive(1, 1, 2, 3, 1, 0, 0, 0);
      tick();
      drive(1, 3, 5, 4, 1, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall !== 1'b0)
         $display("FAIL reset_mid: got a=%0d b=%0d stall=%0d expected 0/0/0", fwd_a_sel, fwd_b_sel, stall);
      else passed++;
      rst_n = 1'b1;
      tick();
      checks++; if (fwd_a_sel !== 2'b00)
         $display("FAIL reset_drops_tag: got a=%0d expected 0", fwd_a_sel);
      else passed++;
   endtask

   task automatic test_raw_ex();
      idle(3);
      drive(1, 1, 2, 3, 1, 0, 0, 0);
      tick();
      drive(1, 3, 5, 4, 1, 0, 0, 0);
      tick();
      checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00)
         $display("FAIL raw_ex: got a=%0d b=%0d expected 1/0", fwd_a_sel, fwd_b_sel);
      else passed++;
      idle(3);
      drive(1, 1, 2, 3, 1, 0, 0, 0);
      tick();
      drive(1, 5, 6, 3, 1, 0, 0, 0);
      tick();
      drive(1, 7, 3, 4, 1, 0, 0, 0);
      tick();
      checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b01)
         $display("FAIL youngest_wins: got a=%0d b=%0d expected 0/1", fwd_a_sel, fwd_b_sel);
      else passed++;
   endtask

   task automatic test_raw_mem_imm();
      idle(3);
      drive(1, 1, 2, 3, 1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 7, 3, 6, 1, 0, 0, 0);
      tick();
      checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10)
         $display("FAIL raw_mem: got a=%0d b=%0d expected 0/2", fwd_a_sel, fwd_b_sel);
      else passed++;
      idle(3);
      drive(1, 1, 2, 3, 1, 0, 0, 0);
      tick();
      drive(1, 3, 3, 8, 1, 0, 1, 0);
      tick();
      checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b11)
         $display("FAIL imm_ex: got a=%0d b=%0d expected 1/3", fwd_a_sel, fwd_b_sel);
      else passed++;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 8, 0, 10, 1, 0, 1, 0);
      tick();
      checks++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b11)
         $display("FAIL imm_mem: got a=%0d b=%0d expected 2/3", fwd_a_sel, fwd_b_sel);
      else passed++;
   endtask

   task automatic test_load_use();
      idle(3);
      drive(1, 1, 0, 2, 1, 1, 1, 0);
      tick();
      drive(1, 2, 1, 9, 1, 0, 0, 0);
      checks++; if (stall !== 1'b1)
         $display("FAIL load_use_stall: got %0d expected 1", stall);
      else passed++;
      tick();
      checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
         $display("FAIL load_use_bubble: got a=%0d b=%0d expected 0/0", fwd_a_sel, fwd_b_sel);
      else passed++;
      drive(1, 2, 1, 9, 1, 0, 0, 0);
      checks++; if (stall !== 1'b0)
         $display("FAIL load_use_one_cycle: got %0d expected 0", stall);
      else passed++;
      tick();
      checks++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00)
         $display("FAIL load_use_resolve: got a=%0d b=%0d expected 2/0", fwd_a_sel, fwd_b_sel);
      else passed++;
      idle(3);
      drive(1, 1, 0, 4, 1, 1, 1, 0);
      tick();
      drive(1, 5, 4, 6, 1, 0, 0, 0);
      checks++; if (stall !== 1'b1)
         $display("FAIL load_use_rt: got %0d expected 1", stall);
      else passed++;
      drive(1, 5, 4, 6, 1, 0, 1, 0);
      checks++; if (stall !== 1'b0)
         $display("FAIL load_use_imm_rt: got %0d expected 0", stall);
      else passed++;
      tick();
   endtask

   task automatic test_r0();
      idle(3);
      drive(1, 1, 2, 0, 1, 0, 0, 0);
      tick();
      drive(1, 0, 0, 5, 1, 0, 0, 0);
      tick();
      checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
         $display("FAIL r0_no_fwd: got a=%0d b=%0d expected 0/0", fwd_a_sel, fwd_b_sel);
      else passed++;
      idle(3);
      drive(1, 1, 0, 0, 1, 1, 1, 0);
      tick();
      drive(1, 0, 0, 5, 1, 0, 0, 0);
      checks++; if (stall !== 1'b0)
         $display("FAIL r0_no_stall: got %0d expected 0", stall);
      else passed++;
      tick();
      checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
         $display("FAIL r0_after_lw: got a=%0d b=%0d expected 0/0", fwd_a_sel, fwd_b_sel);
      else passed++;
   endtask

   task automatic test_flush_hazard();
      idle(3);
      drive(1, 1, 0, 2, 1, 1, 1, 0);
      tick();
      drive(1, 2, 1, 9, 1, 0, 0, 1);
      checks++; if (stall !== 1'b0)
         $display("FAIL flush_no_stall: got %0d expected 0", stall);
      else passed++;
      tick();
      checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
         $display("FAIL flush_bubble: got a=%0d b=%0d expected 0/0", fwd_a_sel, fwd_b_sel);
      else passed++;
      drive(1, 9, 9, 11, 1, 0, 0, 0);
      tick();
      checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
         $display("FAIL flush_discarded: got a=%0d b=%0d expected 0/0", fwd_a_sel, fwd_b_sel);
      else passed++;
   endtask

   task automatic test_random();
      bit v, rw, mr, imm, fl, exp_stall, bub;
      bit [4:0] rs, rt, dst;
      int exp_a, exp_b;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      model_clear();
      for (int n = 0; n < 400; n++) begin
         v   = ($urandom_range(3) != 0);
         rs  = 5'($urandom_range(3));
         rt  = 5'($urandom_range(3));
         dst = 5'($urandom_range(3));
         rw  = ($urandom_range(4) != 0);
         mr  = ($urandom_range(3) == 0);
         imm = ($urandom_range(3) == 0);
         fl  = ($urandom_range(9) == 0);
         drive(v, rs, rt, dst, rw, mr, imm, fl);
         if (n == 200) begin
            rst_n = 1'b0;
            #1;
            model_clear();
            checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
               $display("FAIL rand_reset: got a=%0d b=%0d expected 0/0", fwd_a_sel, fwd_b_sel);
            else passed++;
            rst_n = 1'b1;
         end
         exp_stall = model_stall(v, rs, rt, imm, fl);
         checks++; if (stall !== exp_stall)
            $display("FAIL rand_stall n=%0d: got %0d expected %0d", n, stall, exp_stall);
         else passed++;
         bub   = fl || exp_stall || !v;
         exp_a = bub ? 0 : model_src(rs);
         exp_b = bub ? 0 : (imm ? 3 : model_src(rt));
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         if (fl || exp_stall) pipe[0] = '{0, 0, 0, 0};
         else                 pipe[0] = '{v, dst, rw, mr};
         tick();
         checks++; if (int'(fwd_a_sel) != exp_a || int'(fwd_b_sel) != exp_b)
            $display("FAIL rand_sel n=%0d: got a=%0d b=%0d expected %0d/%0d",
                     n, fwd_a_sel, fwd_b_sel, exp_a, exp_b);
         else passed++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
      id_reg_write = 0; id_mem_read = 0; id_use_imm = 0; flush = 0;
      test_reset();
      test_raw_ex();
      test_raw_mem_imm();
      test_load_use();
      test_r0();
      test_flush_hazard();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
